mtimer_dev: RTL and testbench

MTIMER_DEV -- requirements
Module: mtimer_dev

---
 rtl/mtimer_dev_pkg.sv | 26 ++
 rtl/mtimer_dev_counter.sv | 37 +++
 rtl/mtimer_dev.sv | 96 +++++++++
 tb/tb_mtimer_dev.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_dev_pkg.sv
// Shared definitions for the machine timer device: register offsets, FSM states, reset constants.
package mtimer_dev_pkg;

   localparam logic [15:0] MSIP_OFF     = 16'h0000;
   localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
      logic [63:0] r;
      r = old_val;
      for (int b = 0; b < 8; b++) begin
         if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mtimer_dev_counter.sv
// Free-running mtime counter advanced once every TICK_DIV clocks; a load wins over the tick.
// Load takes effect at the clock edge it is presented on and restarts the prescaler.
module mtime_counter
   import mtimer_dev_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [63:0] load_val,
   output logic [63:0] mtime
);

   localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

   logic [15:0] presc;
   logic        wrap;

   assign wrap = (presc == PRESC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         mtime <= '0;
      end else if (load_en) begin
         presc <= '0;
         mtime <= load_val;
      end else if (wrap) begin
         presc <= '0;
         mtime <= mtime + 64'd1;
      end else begin
         presc <= presc + 16'd1;
      end
   end

endmodule

// File: rtl/mtimer_dev.sv
// Machine timer device (msip, mtimecmp, mtime) behind a one-outstanding request/response port.
// Response appears the cycle after acceptance and is held until rsp_ready; no new request meanwhile.
module mtimer_dev
   import mtimer_dev_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mtip,
   output logic        msip,
   output logic [63:0] mtime
);

   state_t      state;
   logic [63:0] mtimecmp;
   logic        msip_q;
   logic        accept;
   logic        addr_ok;
   logic        wr;
   logic [63:0] rd_val;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign addr_ok   = (req_addr[2:0] == 3'b000) &&
                      (req_addr == MSIP_OFF || req_addr == MTIMECMP_OFF || req_addr == MTIME_OFF);
   assign wr        = accept && req_we && addr_ok;
   assign msip      = msip_q;

   always_comb begin
      rd_val = '0;
      case (req_addr)
         MSIP_OFF:     rd_val = {63'd0, msip_q};
         MTIMECMP_OFF: rd_val = mtimecmp;
         MTIME_OFF:    rd_val = mtime;
         default:      rd_val = '0;
      endcase
   end

   // An all-zero strobe must not disturb the prescaler, so it never reaches the counter.
   mtime_counter #(.TICK_DIV(TICK_DIV)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load_en  (wr && (req_addr == MTIME_OFF) && (|req_wstrb)),
      .load_val (byte_merge(mtime, req_wdata, req_wstrb)),
      .mtime    (mtime)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mtip      <= 1'b0;
         mtimecmp  <= MTIMECMP_RST;
         msip_q    <= 1'b0;
      end else begin
         mtip <= (mtime >= mtimecmp);
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !addr_ok;
                  rsp_rdata <= (addr_ok && !req_we) ? rd_val : '0;
                  if (wr && req_addr == MTIMECMP_OFF)
                     mtimecmp <= byte_merge(mtimecmp, req_wdata, req_wstrb);
                  if (wr && req_addr == MSIP_OFF && req_wstrb[0])
                     msip_q <= req_wdata[0];
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mtimer_dev.sv
// Bench for mtimer_dev: two instances (TICK_DIV 1 and 4) share one bus stimulus and one reference model.
module tb_mtimer_dev;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [7:0]  req_wstrb = '0;
   logic        rsp_ready = 1'b1;
   logic [1:0]  req_ready, rsp_valid, rsp_err, mtip, msip;
   logic [63:0] rsp_rdata [2];
   logic [63:0] mtime [2];

   always #5 clk = ~clk;

   mtimer_dev #(.TICK_DIV(1)) u0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .mtip(mtip[0]),
      .msip(msip[0]), .mtime(mtime[0]));

   mtimer_dev #(.TICK_DIV(4)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .mtip(mtip[1]),
      .msip(msip[1]), .mtime(mtime[1]));

   int total = 0;
   int bad = 0;

   // Reference model: mtime is the last loaded value plus elapsed edges divided by the tick divisor.
   int          divs [2] = '{1, 4};
   int          cyc;
   int          m_bcyc [2];
   logic [63:0] m_base [2];
   logic [63:0] m_cmp;
   logic        m_msip;
   logic        m_mtip [2];
   logic        m_busy;
   logic [63:0] e_rd [2];
   logic        e_err;

   function automatic logic [63:0] mt(input int i);
      return m_base[i] + 64'((cyc - m_bcyc[i]) / divs[i]);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w, input logic [7:0] s);
      logic [63:0] r;
      r = o;
      for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip = 1'b0;
      m_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_bcyc[i] = 0; m_base[i] = '0; m_mtip[i] = 1'b0; e_rd[i] = '0;
      end
      e_err = 1'b0;
   endtask

   task automatic step();
      logic [63:0] pre [2];
      logic        mapped, err;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         pre[i] = mt(i);
         m_mtip[i] = (pre[i] >= m_cmp);
      end
      cyc++;
      if (req_valid && !m_busy) begin
         mapped = (req_addr == 16'h0000) || (req_addr == 16'h4000) || (req_addr == 16'hBFF8);
         err = (req_addr[2:0] != 3'b000) || !mapped;
         e_err = err;
         m_busy = 1'b1;
         for (int i = 0; i < 2; i++) begin
            e_rd[i] = '0;
            if (!err && !req_we)
               e_rd[i] = (req_addr == 16'h0000) ? {63'd0, m_msip} : (req_addr == 16'h4000) ? m_cmp : pre[i];
            if (!err && req_we && req_addr == 16'hBFF8 && req_wstrb != 8'h00) begin
               m_base[i] = merge(pre[i], req_wdata, req_wstrb);
               m_bcyc[i] = cyc;
            end
         end
         if (!err && req_we && req_addr == 16'h4000) m_cmp = merge(m_cmp, req_wdata, req_wstrb);
         if (!err && req_we && req_addr == 16'h0000 && req_wstrb[0]) m_msip = req_wdata[0];
      end else if (m_busy && rsp_ready) begin
         m_busy = 1'b0;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("mtime[%0d]", i), mtime[i], mt(i));
         chk($sformatf("mtip[%0d]", i), 64'(mtip[i]), 64'(m_mtip[i]));
         chk($sformatf("msip[%0d]", i), 64'(msip[i]), 64'(m_msip));
         chk($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(m_busy));
         chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]), 64'(!m_busy));
         if (m_busy) begin
            chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i], e_rd[i]);
            chk($sformatf("rsp_err[%0d]", i), 64'(rsp_err[i]), 64'(e_err));
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                         input logic [7:0] ws, input int hold,
                         output logic [63:0] act_rd, output logic act_err);
      req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      req_valid = 1'b1;
      rsp_ready = (hold == 0);
      step();
      req_valid = 1'b0;
      act_rd = rsp_rdata[0];
      act_err = rsp_err[0];
      for (int k = 0; k < hold; k++) step();
      rsp_ready = 1'b1;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst rsp_valid", 64'(rsp_valid[i]), 64'd0);
         chk("rst rsp_rdata", rsp_rdata[i], 64'd0);
         chk("rst rsp_err", 64'(rsp_err[i]), 64'd0);
         chk("rst mtip", 64'(mtip[i]), 64'd0);
         chk("rst msip", 64'(msip[i]), 64'd0);
         chk("rst mtime", mtime[i], 64'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [63:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t        tbl [14];
   logic [63:0] ard;
   logic        aerr;
   bit          reached;

   initial begin
      tbl[0]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      tbl[1]  = '{1'b1, 16'h0000, 64'hFFFF, 8'h01, 64'h0, 1'b0};
      tbl[2]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b0};
      tbl[3]  = '{1'b1, 16'h0000, 64'h0, 8'hFF, 64'h0, 1'b0};
      tbl[4]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0};
      tbl[5]  = '{1'b0, 16'h4004, 64'h0, 8'h00, 64'h0, 1'b1};
      tbl[6]  = '{1'b0, 16'h1000, 64'h0, 8'h00, 64'h0, 1'b1};
      tbl[7]  = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0};
      tbl[8]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0};
      tbl[9]  = '{1'b1, 16'h4000, 64'h0, 8'h00, 64'h0, 1'b0};
      tbl[10] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0};
      tbl[11] = '{1'b1, 16'h4003, 64'h0, 8'hFF, 64'h0, 1'b1};
      tbl[12] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0};
      tbl[13] = '{1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0};

      repeat (2) @(posedge clk);
      do_reset();

      // Idle after reset.
      repeat (10) step();
      chk("idle10 mtime div1", mtime[0], 64'd10);
      chk("idle10 mtime div4", mtime[1], 64'd2);
      chk("idle10 mtip", 64'(mtip[0]), 64'd0);

      foreach (tbl[v]) begin
         do_req(tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].wstrb, v % 3, ard, aerr);
         chk($sformatf("tbl%0d rdata", v), ard, tbl[v].exp_rd);
         chk($sformatf("tbl%0d err", v), 64'(aerr), 64'(tbl[v].exp_err));
      end

      // Compare threshold: rise one cycle after mtime hits 20, fall after raising mtimecmp.
      do_reset();
      repeat (5) step();
      do_req(1'b1, 16'h4000, 64'd20, 8'hFF, 0, ard, aerr);
      reached = 0;
      for (int k = 0; k < 100 && !reached; k++) begin
         if (mtime[0] == 64'd20) reached = 1;
         else step();
      end
      chk("reach mtime 20", 64'(reached), 64'd1);
      chk("mtip at mtime 20", 64'(mtip[0]), 64'd0);
      step();
      chk("mtip one cycle later", 64'(mtip[0]), 64'd1);
      req_we = 1'b1; req_addr = 16'h4000; req_wdata = 64'd100; req_wstrb = 8'hFF;
      req_valid = 1'b1; rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      chk("mtip after cmp write edge", 64'(mtip[0]), 64'd1);
      step();
      chk("mtip next edge", 64'(mtip[0]), 64'd0);

      // mtime wrap with the divide-by-4 instance.
      do_req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, ard, aerr);
      repeat (2) step();
      chk("div4 hold FE", mtime[1], 64'hFFFF_FFFF_FFFF_FFFE);
      step();
      chk("div4 step FF", mtime[1], 64'hFFFF_FFFF_FFFF_FFFF);
      repeat (3) step();
      chk("div4 hold FF", mtime[1], 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      chk("div4 wrap 0", mtime[1], 64'd0);
      repeat (4) step();

      // Long backpressure, then reset while a response is pending.
      do_req(1'b0, 16'hBFF8, 64'h0, 8'h00, 5, ard, aerr);
      req_we = 1'b1; req_addr = 16'h0000; req_wdata = 64'h1; req_wstrb = 8'h01;
      req_valid = 1'b1; rsp_ready = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      chk("msip before reset", 64'(msip[0]), 64'd1);
      do_reset();
      repeat (3) step();

      // Random traffic against the model.
      for (int n = 0; n < 150; n++) begin
         logic [15:0] a;
         case ($urandom_range(0, 5))
            0: a = 16'h0000;
            1: a = 16'h4000;
            2: a = 16'hBFF8;
            3: a = {16'($urandom_range(0, 65535))} & 16'hFFF8;
            4: a = 16'($urandom_range(0, 65535));
            default: a = 16'h4000 | 16'($urandom_range(1, 7));
         endcase
         do_req(1'($urandom_range(0, 1)), a,
                {32'($urandom), 32'($urandom_range(0, 3))},
                8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), ard, aerr);
         repeat ($urandom_range(0, 3)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

endmodule
